// File: rtl/btn_conditioner_4ch_if.sv
// Pushbutton bundle between the raw board buttons and the conditioned
// per-channel level and pulse outputs of btn_conditioner_4ch.
interface btn_conditioner_4ch_if;
  logic [3:0] btn;       // raw, asynchronous, may bounce
  logic [3:0] btn_db;    // debounced level
  logic [3:0] btn_pe;    // accepted press pulse
  logic [3:0] btn_ne;    // accepted release pulse
  logic [3:0] btn_long;  // long-press pulse
  logic [3:0] btn_rpt;   // auto-repeat pulse

  // Board side: drives raw buttons, consumes conditioned outputs.
  modport master (
    output btn,
    input  btn_db, btn_pe, btn_ne, btn_long, btn_rpt
  );

  // Conditioner side.
  modport slave (
    input  btn,
    output btn_db, btn_pe, btn_ne, btn_long, btn_rpt
  );
endinterface

// File: rtl/btn_conditioner_4ch.sv
// Four independent pushbutton channels: 2-FF synchroniser, debounce counter
// and hold FSM producing a clean level, press/release pulses, a long-press
// pulse and periodic auto-repeat pulses while held. Every output is a flop.
module btn_conditioner_4ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,  // >= 2
  parameter int unsigned LONG_CYCLES     = 100_000_000, // > DEBOUNCE_CYCLES
  parameter int unsigned REPEAT_CYCLES   = 20_000_000   // >= 2
) (
  input  logic                   clk,
  input  logic                   reset_p,
  btn_conditioner_4ch_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,  // btn_db low
    S_PRESS = 2'd1,  // counting towards the long-press threshold
    S_HELD  = 2'd2   // counting auto-repeat periods
  } hold_state_e;

  logic [3:0] w_db;
  logic [3:0] w_pe;
  logic [3:0] w_ne;
  logic [3:0] w_long;
  logic [3:0] w_rpt;

  for (genvar g = 0; g < 4; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic          r_db;
    logic          r_pe;
    logic          r_ne;
    logic [DW-1:0] r_db_cnt;
    hold_state_e   r_state;
    logic [LW-1:0] r_long_cnt;
    logic [RW-1:0] r_rpt_cnt;
    logic          r_long;
    logic          r_rpt;

    logic w_diff;
    logic w_accept;
    logic w_rise;
    logic w_fall;

    // The synchronised level must have differed from btn_db for
    // DEBOUNCE_CYCLES consecutive counted cycles; it is accepted on the
    // edge after the counter has reached that value.
    assign w_diff   = r_sync2 ^ r_db;
    assign w_accept = w_diff && (r_db_cnt == DW'(DEBOUNCE_CYCLES));
    assign w_rise   = w_accept &&  r_sync2;
    assign w_fall   = w_accept && !r_sync2;

    // Two-flop synchroniser for the asynchronous raw button.
    always_ff @(posedge clk or posedge reset_p) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the chain.
      if (reset_p) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= bus.btn[g];
        r_sync2 <= r_sync1;
      end
    end

    // Debounce counter, accepted level and registered edge pulses.
    always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
        r_db_cnt <= '0;
        r_db     <= 1'b0;
        r_pe     <= 1'b0;
        r_ne     <= 1'b0;
      end else begin
        r_pe <= w_rise;
        r_ne <= w_fall;
        if (!w_diff || w_accept) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
        if (w_accept) begin
          r_db <= r_sync2;
        end
      end
    end

    // Hold FSM: long-press after LONG_CYCLES, then a repeat pulse every
    // REPEAT_CYCLES; a release cancels everything in the same edge.
    always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
        r_state    <= S_IDLE;
        r_long_cnt <= '0;
        r_rpt_cnt  <= '0;
        r_long     <= 1'b0;
        r_rpt      <= 1'b0;
      end else begin
        r_long <= 1'b0;
        r_rpt  <= 1'b0;
        if (w_fall) begin
          r_state    <= S_IDLE;
          r_long_cnt <= '0;
          r_rpt_cnt  <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_rise) begin
                r_state    <= S_PRESS;
                r_long_cnt <= '0;
              end
            end
            S_PRESS: begin
              if (r_long_cnt == LW'(LONG_CYCLES - 1)) begin
                r_state    <= S_HELD;
                r_long     <= 1'b1;
                r_long_cnt <= '0;
                r_rpt_cnt  <= '0;
              end else begin
                r_long_cnt <= r_long_cnt + 1'b1;
              end
            end
            S_HELD: begin
              if (r_rpt_cnt == RW'(REPEAT_CYCLES - 1)) begin
                r_rpt     <= 1'b1;
                r_rpt_cnt <= '0;
              end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
              end
            end
            default: begin
              r_state    <= S_IDLE;
              r_long_cnt <= '0;
              r_rpt_cnt  <= '0;
            end
          endcase
        end
      end
    end

    assign w_db[g]   = r_db;
    assign w_pe[g]   = r_pe;
    assign w_ne[g]   = r_ne;
    assign w_long[g] = r_long;
    assign w_rpt[g]  = r_rpt;
  end

  assign bus.btn_db   = w_db;
  assign bus.btn_pe   = w_pe;
  assign bus.btn_ne   = w_ne;
  assign bus.btn_long = w_long;
  assign bus.btn_rpt  = w_rpt;

endmodule
